// File: rtl/logisim_arb_pkg.sv
// Shared types and defaults for the logisim output-field arbiters.
package logisim_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } arbState_e;

    localparam int ARB_N_REQ    = 4;
    localparam int ARB_DATA_W   = 4;
    localparam int ARB_HOLD_CYC = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/logisim_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// the pointer, wrapping at N_REQ-1.
module logisim_rr_pick
    import logisim_arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    localparam int SEL_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N_REQ-1:0] winOneHot_o,
    output logic [SEL_W-1:0] winIdx_o,
    output logic             anyReq_o
);

    // N_REQ is a power of two, so the SEL_W-bit sum wraps to lane 0 by itself.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] cand;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        cand  = ptr_i;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_i + SEL_W'(k);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        anyReq_o    = found;
        winIdx_o    = idx;
        winOneHot_o = found ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/logisim_out_arbiter.sv
// Round-robin arbiter sharing the upper io_out field between requesters.
// Optional lane-0 priority is enabled by defining LOGISIM_ARB_PRIO0_EN.
module logisim_out_arbiter
    import logisim_arb_pkg::*;
#(
    parameter int N_REQ    = ARB_N_REQ,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int HOLD_CYC = ARB_HOLD_CYC,
    localparam int SEL_W   = clog2(N_REQ),
    localparam int CNT_W   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ*DATA_W-1:0] DATA,
    output logic [N_REQ-1:0]        GNT,
    output logic [DATA_W-1:0]       OUT_DATA,
    output logic                    OUT_VALID,
    output logic [SEL_W-1:0]        OUT_SEL
);

    arbState_e         state_q;
    logic              rstSync_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [DATA_W-1:0] outData_q;
    logic              outValid_q;
    logic [SEL_W-1:0]  outSel_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  ptr_d;
    logic [CNT_W-1:0]  holdCnt_q;

    logic [N_REQ-1:0]  rrOneHot;
    logic [SEL_W-1:0]  rrIdx;
    logic              rrAny;
    logic [N_REQ-1:0]  winOneHot;
    logic [SEL_W-1:0]  winIdx;

    logisim_rr_pick #(.N_REQ(N_REQ)) uPick (
        .req_i       (REQ),
        .ptr_i       (ptr_q),
        .winOneHot_o (rrOneHot),
        .winIdx_o    (rrIdx),
        .anyReq_o    (rrAny)
    );

    always_comb begin
        winOneHot = rrOneHot;
        winIdx    = rrIdx;
        ptr_d     = rrIdx + SEL_W'(1);
`ifdef LOGISIM_ARB_PRIO0_EN
        if (REQ[0]) begin
            winOneHot = N_REQ'(1);
            winIdx    = '0;
            ptr_d     = ptr_q;
        end
`endif
    end

    // Reset asserts asynchronously but is released one edge after RST rises.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rstSync_q <= 1'b0;
        else      rstSync_q <= 1'b1;
    end

    // The gap cycle doubles as the arbitration slot, so grants are HOLD_CYC+1 apart.
    always_ff @(posedge CLK or negedge rstSync_q) begin
        if (!rstSync_q) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outSel_q   <= '0;
            ptr_q      <= '0;
            holdCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    if (rrAny) begin
                        gnt_q      <= winOneHot;
                        outData_q  <= DATA[int'(winIdx)*DATA_W +: DATA_W];
                        outSel_q   <= winIdx;
                        outValid_q <= 1'b1;
                        holdCnt_q  <= CNT_W'(HOLD_CYC - 1);
                        ptr_q      <= ptr_d;
                        state_q    <= DRIVE;
                    end else begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                DRIVE: begin
                    gnt_q <= '0;
                    if (holdCnt_q == '0) begin
                        outValid_q <= 1'b0;
                        state_q    <= GAP;
                    end else begin
                        holdCnt_q <= holdCnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign GNT       = gnt_q;
    assign OUT_DATA  = outData_q;
    assign OUT_VALID = outValid_q;
    assign OUT_SEL   = outSel_q;

endmodule

// File: tb/tb_logisim_out_arbiter.sv
// Directed self-checking bench for logisim_out_arbiter (default parameters).
module tb_logisim_out_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [15:0] DATA;
    logic [3:0]  GNT;
    logic [3:0]  OUT_DATA;
    logic        OUT_VALID;
    logic [1:0]  OUT_SEL;

    int checkCount;
    int errorCount;

    logisim_out_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .DATA      (DATA),
        .GNT       (GNT),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_SEL   (OUT_SEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [15:0] data);
        REQ  = req;
        DATA = data;
    endtask

    task automatic checkGrant(input string tag, input int lane, input logic [3:0] data);
        checkOutput({tag, "_gnt"},   32'(GNT),       32'(1) << lane);
        checkOutput({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
        checkOutput({tag, "_data"},  32'(OUT_DATA),  32'(data));
        checkOutput({tag, "_sel"},   32'(OUT_SEL),   32'(lane));
    endtask

    // Expect two quiet-grant cycles (hold tail, gap) and then the next grant.
    task automatic expectNextGrant(input string tag, input int lane, input logic [3:0] data);
        @(negedge CLK);
        checkOutput({tag, "_hold_gnt"},   32'(GNT),       32'd0);
        checkOutput({tag, "_hold_valid"}, 32'(OUT_VALID), 32'd1);
        @(negedge CLK);
        checkOutput({tag, "_gap_gnt"},    32'(GNT),       32'd0);
        checkOutput({tag, "_gap_valid"},  32'(OUT_VALID), 32'd0);
        @(negedge CLK);
        checkGrant(tag, lane, data);
    endtask

    initial begin
        int rotLane[4];
        checkCount = 0;
        errorCount = 0;
        RST = 1'b0;
        applyStimulus(4'hF, 16'h4321);

        $display("[TB] reset held with all requests high");
        repeat (3) begin
            @(negedge CLK);
            checkOutput("rst_gnt",   32'(GNT),       32'd0);
            checkOutput("rst_valid", 32'(OUT_VALID), 32'd0);
            checkOutput("rst_data",  32'(OUT_DATA),  32'd0);
            checkOutput("rst_sel",   32'(OUT_SEL),   32'd0);
        end
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("rel_edge1_gnt", 32'(GNT), 32'd0);
        @(negedge CLK);
        checkGrant("rel_edge2", 0, 4'h1);

        $display("[TB] rotation with all requests high");
`ifdef LOGISIM_ARB_PRIO0_EN
        rotLane = '{0, 0, 0, 0};
`else
        rotLane = '{1, 2, 3, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            expectNextGrant($sformatf("rot%0d", i), rotLane[i], 4'(rotLane[i] + 1));
        end
        applyStimulus(4'h0, 16'h4321);
        repeat (3) @(negedge CLK);
        checkOutput("idle_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("idle_gnt",   32'(GNT),       32'd0);

        $display("[TB] single request on lane 2");
        applyStimulus(4'b0100, 16'h4A21);
        @(negedge CLK);
        checkGrant("single", 2, 4'hA);
        applyStimulus(4'b0000, 16'h4A21);
        @(negedge CLK);
        checkOutput("single_hold_gnt",   32'(GNT),       32'd0);
        checkOutput("single_hold_valid", 32'(OUT_VALID), 32'd1);
        checkOutput("single_hold_data",  32'(OUT_DATA),  32'hA);
        @(negedge CLK);
        checkOutput("single_gap_valid",  32'(OUT_VALID), 32'd0);
        checkOutput("single_gap_data",   32'(OUT_DATA),  32'hA);
        checkOutput("single_gap_sel",    32'(OUT_SEL),   32'd2);
        @(negedge CLK);
        checkOutput("single_idle_gnt",   32'(GNT),       32'd0);

        $display("[TB] pointer at 3 wraps to lane 0");
        applyStimulus(4'b0001, 16'h4A21);
        @(negedge CLK);
        checkGrant("wrap", 0, 4'h1);

        applyStimulus(4'b0000, 16'h4A2F);
        @(negedge CLK);
        checkOutput("freeze_data",  32'(OUT_DATA),  32'h1);
        checkOutput("freeze_valid", 32'(OUT_VALID), 32'd1);
        RST = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("abort_data",  32'(OUT_DATA),  32'd0);
        checkOutput("abort_sel",   32'(OUT_SEL),   32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("abort_rel_valid", 32'(OUT_VALID), 32'd0);

`ifdef LOGISIM_ARB_PRIO0_EN
        $display("[TB] lane 0 priority then round-robin among the rest");
        applyStimulus(4'hF, 16'h4321);
        @(negedge CLK);
        checkGrant("prio0", 0, 4'h1);
        expectNextGrant("prio1", 0, 4'h1);
        applyStimulus(4'hE, 16'h4321);
        expectNextGrant("prio_rr1", 1, 4'h2);
        expectNextGrant("prio_rr2", 2, 4'h3);
        expectNextGrant("prio_rr3", 3, 4'h4);
`else
        $display("[TB] grant after abort starts from pointer 0");
        applyStimulus(4'b0010, 16'h4A2F);
        @(negedge CLK);
        checkGrant("post_abort", 1, 4'h2);
`endif

        $display("[TB] withdrawn request is never granted");
        applyStimulus(4'b1000, 16'h4A2F);
        @(negedge CLK);
        applyStimulus(4'b0000, 16'h4A2F);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("withdraw_gnt", 32'(GNT), 32'd0);
        end
        checkOutput("withdraw_valid", 32'(OUT_VALID), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
